// File: rtl/ext_unit.sv
// Zero/sign extender from IN_W to OUT_W bits. Provides a combinational result and a
// registered copy with a valid flag for pipelined consumers.
module ext_unit #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sign,
  input  logic [IN_W-1:0]  din,
  input  logic             in_valid,
  output logic [OUT_W-1:0] dout,
  output logic [OUT_W-1:0] dout_q,
  output logic             out_valid
);

  generate
    if (IN_W < 1 || IN_W > OUT_W) begin : g_param_check
      $error("ext_unit: IN_W must be in 1..OUT_W");
      assign dout = '0;
    end else if (IN_W == OUT_W) begin : g_pass
      assign dout = din;
    end else begin : g_extend
      // X on sign only reaches the upper bits when the field MSB is 1
      assign dout = {{(OUT_W-IN_W){sign & din[IN_W-1]}}, din};
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_q    <= '0;
      out_valid <= 1'b0;
    end else if (in_valid) begin
      dout_q    <= dout;
      out_valid <= 1'b1;
    end else begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ext_unit.sv
// Directed self-checking bench for ext_unit: three widths (1->32, 16->32, 32->32),
// registered path, asynchronous reset and streaming.
module tb_ext_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        sign16 = 1'b0;
  logic [15:0] din16 = '0;
  logic        in_valid16 = 1'b0;
  logic [31:0] dout16, dout_q16;
  logic        out_valid16;

  logic        sign1 = 1'b0;
  logic [0:0]  din1 = '0;
  logic        in_valid1 = 1'b0;
  logic [31:0] dout1, dout_q1;
  logic        out_valid1;

  logic        sign32 = 1'b0;
  logic [31:0] din32 = '0;
  logic        in_valid32 = 1'b0;
  logic [31:0] dout32, dout_q32;
  logic        out_valid32;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ext_unit #(.IN_W(16), .OUT_W(32)) u16 (
    .clk(clk), .rst_n(rst_n), .sign(sign16), .din(din16), .in_valid(in_valid16),
    .dout(dout16), .dout_q(dout_q16), .out_valid(out_valid16)
  );

  ext_unit #(.IN_W(1), .OUT_W(32)) u1 (
    .clk(clk), .rst_n(rst_n), .sign(sign1), .din(din1), .in_valid(in_valid1),
    .dout(dout1), .dout_q(dout_q1), .out_valid(out_valid1)
  );

  ext_unit #(.IN_W(32), .OUT_W(32)) u32 (
    .clk(clk), .rst_n(rst_n), .sign(sign32), .din(din32), .in_valid(in_valid32),
    .dout(dout32), .dout_q(dout_q32), .out_valid(out_valid32)
  );

  task automatic test_reset;
    din16 = 16'h8000; sign16 = 1'b1;
    #2;
    checks++;
    if (dout_q16 !== 32'h0) begin
      failures++; $display("FAIL reset_dout_q: got %h want %h", dout_q16, 32'h0);
    end
    checks++;
    if (out_valid16 !== 1'b0) begin
      failures++; $display("FAIL reset_out_valid: got %b want 0", out_valid16);
    end
    checks++;
    if (dout16 !== 32'hFFFF_8000) begin
      failures++; $display("FAIL reset_dout_comb: got %h want %h", dout16, 32'hFFFF_8000);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_w1;
    logic [31:0] exp [4];
    exp[0] = 32'h0; exp[1] = 32'h1; exp[2] = 32'h0; exp[3] = 32'hFFFF_FFFF;
    for (int i = 0; i < 4; i++) begin
      sign1 = i[1];
      din1  = i[0];
      #1;
      checks++;
      if (dout1 !== exp[i]) begin
        failures++; $display("FAIL w1_sign%0b_din%0b: got %h want %h", sign1, din1, dout1, exp[i]);
      end
    end
  endtask

  task automatic test_w16_comb;
    logic [15:0] d [4];
    logic        s [4];
    logic [31:0] exp [4];
    d[0] = 16'h8000; s[0] = 1'b1; exp[0] = 32'hFFFF_8000;
    d[1] = 16'h8000; s[1] = 1'b0; exp[1] = 32'h0000_8000;
    d[2] = 16'h7FFF; s[2] = 1'b1; exp[2] = 32'h0000_7FFF;
    d[3] = 16'hFFFF; s[3] = 1'b0; exp[3] = 32'h0000_FFFF;
    for (int i = 0; i < 4; i++) begin
      din16 = d[i]; sign16 = s[i];
      #1;
      checks++;
      if (dout16 !== exp[i]) begin
        failures++; $display("FAIL w16_comb_%0d: got %h want %h", i, dout16, exp[i]);
      end
    end
  endtask

  task automatic test_w32;
    din32 = 32'h8000_0001; sign32 = 1'b1;
    #1;
    checks++;
    if (dout32 !== 32'h8000_0001) begin
      failures++; $display("FAIL w32_sign1: got %h want %h", dout32, 32'h8000_0001);
    end
    sign32 = 1'b0;
    #1;
    checks++;
    if (dout32 !== 32'h8000_0001) begin
      failures++; $display("FAIL w32_sign0: got %h want %h", dout32, 32'h8000_0001);
    end
  endtask

  task automatic test_registered;
    @(negedge clk);
    din16 = 16'hFFFF; sign16 = 1'b1; in_valid16 = 1'b1;
    @(posedge clk); #1;
    in_valid16 = 1'b0; din16 = 16'h1234; sign16 = 1'b0;
    checks++;
    if (dout_q16 !== 32'hFFFF_FFFF) begin
      failures++; $display("FAIL reg_capture: got %h want %h", dout_q16, 32'hFFFF_FFFF);
    end
    checks++;
    if (out_valid16 !== 1'b1) begin
      failures++; $display("FAIL reg_valid: got %b want 1", out_valid16);
    end
    @(posedge clk); #1;
    checks++;
    if (out_valid16 !== 1'b0) begin
      failures++; $display("FAIL idle_valid: got %b want 0", out_valid16);
    end
    checks++;
    if (dout_q16 !== 32'hFFFF_FFFF) begin
      failures++; $display("FAIL idle_hold: got %h want %h", dout_q16, 32'hFFFF_FFFF);
    end
  endtask

  task automatic test_async_reset;
    @(negedge clk);
    din16 = 16'h00C3; sign16 = 1'b0; in_valid16 = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (out_valid16 !== 1'b1 || dout_q16 !== 32'h0000_00C3) begin
      failures++; $display("FAIL pre_reset: got %b/%h want 1/%h", out_valid16, dout_q16, 32'h0000_00C3);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (dout_q16 !== 32'h0 || out_valid16 !== 1'b0) begin
      failures++; $display("FAIL async_reset: got %b/%h want 0/%h", out_valid16, dout_q16, 32'h0);
    end
    din16 = 16'h80AB; sign16 = 1'b1;
    #1;
    checks++;
    if (dout16 !== 32'hFFFF_80AB) begin
      failures++; $display("FAIL reset_dout_tracks: got %h want %h", dout16, 32'hFFFF_80AB);
    end
    // in_valid still high across an edge while reset is held
    @(posedge clk); #1;
    checks++;
    if (dout_q16 !== 32'h0 || out_valid16 !== 1'b0) begin
      failures++; $display("FAIL reset_wins: got %b/%h want 0/%h", out_valid16, dout_q16, 32'h0);
    end
    @(negedge clk);
    in_valid16 = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (dout_q16 !== 32'h0 || out_valid16 !== 1'b0) begin
      failures++; $display("FAIL post_reset_idle: got %b/%h want 0/%h", out_valid16, dout_q16, 32'h0);
    end
  endtask

  task automatic test_back_to_back;
    logic [15:0] d [4];
    logic [31:0] exp [4];
    d[0] = 16'h0001; exp[0] = 32'h0000_0001;
    d[1] = 16'h0002; exp[1] = 32'h0000_0002;
    d[2] = 16'h0003; exp[2] = 32'h0000_0003;
    d[3] = 16'hFFFC; exp[3] = 32'hFFFF_FFFC;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      din16 = d[i]; sign16 = 1'b1; in_valid16 = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (dout_q16 !== exp[i] || out_valid16 !== 1'b1) begin
        failures++; $display("FAIL stream_%0d: got %b/%h want 1/%h", i, out_valid16, dout_q16, exp[i]);
      end
    end
    in_valid16 = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (dout_q16 !== 32'hFFFF_FFFC || out_valid16 !== 1'b0) begin
      failures++; $display("FAIL stream_end: got %b/%h want 0/%h", out_valid16, dout_q16, 32'hFFFF_FFFC);
    end
  endtask

  initial begin
    test_reset();
    test_w1();
    test_w16_comb();
    test_w32();
    test_registered();
    test_async_reset();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ext_unit.md
# ext_unit

Parameterised bit-width extender used in the datapath ahead of the ALU. It widens an `IN_W`-bit field to `OUT_W` bits by zero- or sign-extension. Typical uses:
- building the all-ones/all-zeros B-invert mask from the 1-bit subtract control;
- forming the 0/1 constants for set-less-than results;
- extending immediates.

A combinational result is always available. A registered copy with a valid flag serves pipelined consumers.

## Interface
Parameters:
- `IN_W`, default 16: width of the input field; legal range 1..`OUT_W`.
- `OUT_W`, default 32: width of the extended result; `OUT_W` ≥ `IN_W` ≥ 1.

Ports:
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `sign` in 1: extension mode; 1 = sign-extend (replicate `din[IN_W-1]`), 0 = zero-extend.
- `din` in `IN_W`: field to extend.
- `in_valid` in 1: qualifies `din`/`sign` for capture into the output register.
- `dout` out `OUT_W`: combinational extended value.
- `dout_q` out `OUT_W`: registered extended value.
- `out_valid` out 1: `dout_q` holds a value captured on the previous cycle.

## Operation
- Bit mapping: `dout[IN_W-1:0] = din`.
- Upper bits `dout[OUT_W-1:IN_W]` are all `din[IN_W-1]` when `sign`=1, and all 0 when `sign`=0.
- When `IN_W == OUT_W`, `dout = din` and `sign` is ignored. No zero-width slice may be generated; guard with generate.
- When `IN_W == 1`, the single input bit is also the MSB:
  - `sign=1, din=1` gives all ones.
  - `sign=0, din=1` gives 32'h0000_0001.
  - `din=0` gives zero for either `sign`.
- `dout` is purely combinational from `sign`/`din`. It does not depend on `clk` or `rst_n` and is valid during reset.
- Registered path, on each rising `clk` with `rst_n`=1:
  - If `in_valid`=1: `dout_q` ← extended value, `out_valid` ← 1.
  - If `in_valid`=0: `dout_q` holds, `out_valid` ← 0.
- There is no back-pressure. Every `in_valid` beat is captured and any undelivered value is overwritten.
- Parameter check: elaboration fails (`$error` in a generate block) if `IN_W < 1` or `IN_W > OUT_W`.
- X on `sign` with `din` MSB = 1 may propagate X to the upper bits. No X-masking is done.

## Timing
- `dout`: zero-cycle latency.
- `dout_q`/`out_valid`: one-cycle latency. A value presented with `in_valid` in cycle N appears in cycle N+1.
- Reset: asserting `rst_n`=0 at any time immediately forces `dout_q`=0 and `out_valid`=0, without waiting for a clock edge.
- Reset mid-stream discards the in-flight value.
- On deassertion, the first capture happens on the first rising edge with `rst_n`=1 and `in_valid`=1.
- Back-to-back `in_valid` gives one result per cycle with no bubbles.
- Simultaneous `rst_n` low and `in_valid` high: reset wins.
- `rst_n` deassertion must be synchronised externally to `clk` (recovery/removal timing met).

## Test plan
- `IN_W=1, OUT_W=32`, sweep `sign,din` ∈ {00,01,10,11} -> `dout` = 0, 32'h1, 0, 32'hFFFF_FFFF respectively.
- `IN_W=16`:
  - `din=16'h8000, sign=1` -> `dout=32'hFFFF_8000`.
  - `sign=0` -> `32'h0000_8000`.
  - `din=16'h7FFF, sign=1` -> `32'h0000_7FFF`.
- `IN_W=OUT_W=32`, `din=32'h8000_0001`, `sign=1` -> `dout=32'h8000_0001`.
- Registered path:
  - `in_valid` pulses with `din=16'hFFFF, sign=1` -> next cycle `dout_q=32'hFFFF_FFFF`, `out_valid=1`.
  - The following idle cycle -> `out_valid=0`, `dout_q` unchanged.
- Async reset: drive `rst_n`=0 between clock edges while `out_valid`=1 -> `dout_q=0` and `out_valid=0` immediately. `dout` still tracks `din`.
- Streaming: `in_valid` high for 4 cycles with `din` = 1, 2, 3, 16'hFFFC (`sign=1`) -> `dout_q` = 1, 2, 3, 32'hFFFF_FFFC on consecutive cycles.
